pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_entry.sv | 24 ++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: types and default widths shared by the pipeline stage registers.
// The occupancy encoding is the state encoding, so occupancy is a direct map.
package pipe_pkg;

    localparam int CTRL_W_DEF = 12;
    localparam int DATA_W_DEF = 136;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HEAD  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    function automatic logic [1:0] state_occ(input stage_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        unique case (s)
            EMPTY:   occ = 2'd0;
            HEAD:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one stage entry (control + data) with load enable.
// Cleared asynchronously so a reset stage never exposes stale bundles.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int W = CTRL_W_DEF + DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // entry storage: clear on reset, capture when loaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry.
// With a skid entry in_ready is registered, cutting the out_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int  EW       = CTRL_W + DATA_W;
    localparam bit  HAS_SKID = (SKID != 0);

    stage_state_t    state_q;
    stage_state_t    state_d;
    logic            in_xfer;
    logic            out_xfer;
    logic            head_ld;
    logic            skid_ld;
    logic [EW-1:0]   in_ent;
    logic [EW-1:0]   head_d;
    logic [EW-1:0]   head_q;
    logic [EW-1:0]   skid_q;

    assign in_ent    = {in_ctrl, in_data};
    assign out_valid = (state_q != EMPTY);
    // a flushed cycle never accepts, whatever the handshake says
    assign in_xfer   = in_valid & in_ready & ~flush;
    assign out_xfer  = out_valid & out_ready;

    // occupancy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and entry load selects; flush overrides everything
    always_comb begin
        state_d = state_q;
        head_ld = 1'b0;
        skid_ld = 1'b0;
        head_d  = in_ent;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = HEAD;
                        head_ld = 1'b1;
                    end
                end
                HEAD: begin
                    if (in_xfer && out_xfer) begin
                        head_ld = 1'b1;
                    end else if (in_xfer && HAS_SKID) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d = HEAD;
                        head_ld = 1'b1;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    pipe_entry #(
        .W (EW)
    ) u_head (
        .clk (clk),
        .rst (rst),
        .ld  (head_ld),
        .d   (head_d),
        .q   (head_q)
    );

    generate
        if (HAS_SKID) begin : g_skid
            logic rdy_q;

            pipe_entry #(
                .W (EW)
            ) u_skid (
                .clk (clk),
                .rst (rst),
                .ld  (skid_ld),
                .d   (in_ent),
                .q   (skid_q)
            );

            // ready is the registered "not full next cycle"
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdy_q <= 1'b0;
                end else begin
                    rdy_q <= (state_d != FULL);
                end
            end

            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign skid_q   = '0;
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign out_ctrl  = out_valid ? head_q[EW-1:DATA_W] : '0;
    assign out_data  = head_q[DATA_W-1:0];
    assign occupancy = state_occ(state_q);

endmodule
